// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the two requester handshakes and the
// transmitter-side outputs of uart_tx_arbiter. The slave modport is the
// arbiter's view. The master modport is the view of the surrounding logic,
// which drives the requests and observes the grants and the write strobe.
interface uart_tx_arbiter_if;
  logic       req0;
  logic [7:0] data0;
  logic       gnt0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt1;
  logic       write;
  logic [7:0] write_value;
  logic       busy;

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, write, write_value, busy
  );

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, write, write_value, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two requesters.
// A request seen in IDLE is granted for exactly one cycle. In that cycle
// write pulses with the winner's byte. The block then waits one full frame
// (CLKS_PER_BIT*FRAME_BITS cycles) before it accepts the next request.
//
// Configuration macro: UART_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin. On a tie, the requester not granted
//                         last wins.
//   defined             : fixed priority. Requester 0 always wins a tie, and
//                         the last-granted register is not built.
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FRAME_BITS   = 11
) (
  input  logic                  clk_50M,
  input  logic                  reset,
  uart_tx_arbiter_if.slave      bus
);

  localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS;
  // Wide enough to hold FRAME_CYCLES-1.
  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [7:0]       wval_q, wval_d;
  logic             busy_q, busy_d;
  logic             win_s;            // 1'b1 when requester 1 wins arbitration

`ifdef UART_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 1 wins only when requester 0 is not requesting.
  always_comb begin
    win_s = ~bus.req0;
  end
`else
  logic last_q, last_d;               // requester granted most recently

  // Round-robin: on a tie, pick the requester that was not granted last.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      win_s = ~last_q;
    end else begin
      win_s = bus.req1;
    end
  end
`endif

  // Next-state, grant and counter logic for the IDLE/GRANT/WAIT sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    wval_d  = wval_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // The outputs are registered. Setting them here makes the grant
          // visible in the cycle right after the request is sampled.
          state_d = ST_GRANT;
          write_d = 1'b1;
          gnt0_d  = ~win_s;
          gnt1_d  = win_s;
          wval_d  = win_s ? bus.data1 : bus.data0;
`ifndef UART_ARB_FIXED_PRIO_EN
          last_d  = win_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_LOAD;
      end
      ST_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers, with synchronous reset.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      write_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      wval_q  <= 8'h00;
      busy_q  <= 1'b0;
`ifndef UART_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      wval_q  <= wval_d;
      busy_q  <= busy_d;
`ifndef UART_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.gnt0        = gnt0_q;
  assign bus.gnt1        = gnt1_q;
  assign bus.write       = write_q;
  assign bus.write_value = wval_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with
// CLKS_PER_BIT=4 and FRAME_BITS=11, giving a 44-cycle frame.
// Each expected write (requester id, byte, cycle) is queued when its
// stimulus is driven. A negedge monitor pops and compares it when write
// is observed.
module tb_uart_tx_arbiter;

  localparam int FC = 44;               // frame cycles
  localparam int SPACING = FC + 2;      // cycles between write pulses

  typedef struct {
    logic       id;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_gnt0 = 0;
  int   n_gnt1 = 0;
  exp_t sb_q[$];

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.CLKS_PER_BIT(4), .FRAME_BITS(11)) dut (
    .clk_50M (clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [7:0] val, input int at);
    exp_t e;
    e.id  = id;
    e.val = val;
    e.cyc = at;
    sb_q.push_back(e);
  endtask

  // Monitor: pop the scoreboard on each write and check the grant handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gnt0) n_gnt0++;
      if (bus.gnt1) n_gnt1++;
      if (bus.write || bus.gnt0 || bus.gnt1) begin
        chk("gnt_onehot_with_write", {bus.write, bus.gnt0, bus.gnt1},
            {1'b1, ~bus.gnt1, bus.gnt1});
        chk("busy_in_grant", bus.busy, 1'b1);
        if (bus.write) begin
          chk("write_expected", (sb_q.size() != 0), 1'b1);
          if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("wr_id", bus.gnt1, e.id);
            chk("wr_val", bus.write_value, e.val);
            chk("wr_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sb_empty(input int budget, input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, sb_q.size(), 32'd0);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, bus.busy, 1'b0);
  endtask

  // Watchdog: stops a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int busy_cnt;
    int x;
    int g0;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = 8'h00;
    bus.data1 = 8'h00;
    rst = 1'b1;
    step(3);
    chk("rst_write", bus.write, 1'b0);
    chk("rst_gnt", {bus.gnt0, bus.gnt1}, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_wval", bus.write_value, 8'h00);
    rst = 1'b0;
    step(2);
    chk("idle_no_busy", bus.busy, 1'b0);

    // Single request: one write of 8'h12, then busy for 45 cycles in total.
    bus.data0 = 8'h12;
    bus.req0  = 1'b1;
    g = cyc + 1;
    push(1'b0, 8'h12, g);
    wait_sb_empty(10, "t1_grant_seen");
    bus.req0 = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < FC; i++) begin
      if (bus.busy) busy_cnt++;
      step(1);
    end
    chk("t1_busy_cycles", busy_cnt, FC);
    chk("t1_busy_low_after", bus.busy, 1'b0);
    chk("t1_wval_held", bus.write_value, 8'h12);

    // Tie with both requests held, starting from reset state.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    bus.data0 = 8'h34;
    bus.data1 = 8'h56;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    g = cyc + 1;
    for (int i = 0; i < 4; i++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
      push(1'b0, 8'h34, g + i * SPACING);
`else
      push(i[0], (i[0] ? 8'h56 : 8'h34), g + i * SPACING);
`endif
    end
    wait_sb_empty(4 * SPACING + 10, "t2_four_grants");
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle(SPACING + 5, "t2_idle");
    chk("t2_wval_held", bus.write_value,
`ifdef UART_ARB_FIXED_PRIO_EN
        8'h34
`else
        8'h56
`endif
        );

    // A request raised 10 cycles into WAIT waits for IDLE.
    bus.data0 = 8'h11;
    bus.req0  = 1'b1;
    g = cyc + 1;
    push(1'b0, 8'h11, g);
    wait_sb_empty(10, "t3_first_grant");
    bus.req0 = 1'b0;
    step(10);
    bus.data1 = 8'h78;
    bus.req1  = 1'b1;
    push(1'b1, 8'h78, g + SPACING);
    wait_sb_empty(SPACING + 10, "t3_late_grant");
    bus.req1 = 1'b0;
    wait_idle(SPACING + 5, "t3_idle");

    // Reset in the middle of WAIT aborts the frame wait.
    bus.data0 = 8'h9A;
    bus.req0  = 1'b1;
    g = cyc + 1;
    push(1'b0, 8'h9A, g);
    wait_sb_empty(10, "t4_first_grant");
    step(10);
    chk("t4_busy_mid_wait", bus.busy, 1'b1);
    rst = 1'b1;
    step(1);
    chk("t4_busy_after_rst", bus.busy, 1'b0);
    chk("t4_write_after_rst", bus.write, 1'b0);
    chk("t4_wval_after_rst", bus.write_value, 8'h00);
    rst = 1'b0;
    x = cyc;
    push(1'b0, 8'h9A, x + 1);
    wait_sb_empty(4, "t4_regrant");
    bus.req0 = 1'b0;
    wait_idle(SPACING + 5, "t4_idle");

    // A one-cycle pulse on req0 during WAIT must not be granted.
    bus.data1 = 8'hC3;
    bus.req1  = 1'b1;
    push(1'b1, 8'hC3, cyc + 1);
    wait_sb_empty(10, "t5_grant");
    bus.req1 = 1'b0;
    step(5);
    g0 = n_gnt0;
    bus.data0 = 8'hEE;
    bus.req0  = 1'b1;
    step(1);
    bus.req0  = 1'b0;
    wait_idle(SPACING + 5, "t5_idle");
    step(10);
    chk("t5_no_gnt0", n_gnt0 - g0, 32'd0);
    chk("t5_no_write_left", bus.write, 1'b0);
    chk("t5_wval_held", bus.write_value, 8'hC3);
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5208, clock cycles per UART bit (50 MHz / 9600 baud).
REQ-002 The block SHALL have parameter FRAME_BITS, default 11, bits per frame (start + 8 data + even parity + stop).
REQ-003 The block SHALL have one clock and a synchronous active-high reset; all ports below are in clk_50M's domain.
REQ-004 clk_50M  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0  input  1  requester 0 transmit request, level, held until gnt0.
REQ-007 data0  input  8  requester 0 byte, stable while req0 high.
REQ-008 gnt0  output  1  one-cycle grant/ack; data0 captured this cycle.
REQ-009 req1  input  1  requester 1 transmit request, level, held until gnt1.
REQ-010 data1  input  8  requester 1 byte, stable while req1 high.
REQ-011 gnt1  output  1  one-cycle grant/ack; data1 captured this cycle.
REQ-012 write  output  1  one-cycle start pulse to the UART transmitter.
REQ-013 write_value  output  8  byte to the transmitter, valid while write high, held afterwards.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 FRAME_CYCLES SHALL equal CLKS_PER_BIT*FRAME_BITS (57288 at defaults); the wait counter SHALL be wide enough to hold FRAME_CYCLES-1 without overflow.
REQ-016 The FSM SHALL have three states: IDLE, GRANT, WAIT.
- IDLE: any req sampled high -> GRANT, winner registered.
- GRANT: exactly 1 cycle; write=1, write_value=winner's data, gnt of winner=1; counter loaded FRAME_CYCLES-1; -> WAIT.
- WAIT: counter decrements each cycle; at 0 -> IDLE.
REQ-017 write, gnt0 and gnt1 SHALL be registered outputs, high only in GRANT, and gnt0 and gnt1 SHALL never both be high.
REQ-018 Latency: a request sampled in IDLE at edge k SHALL produce write/gnt in the cycle after edge k.
REQ-019 Spacing: with continuous requests, write rising edges SHALL be exactly FRAME_CYCLES+2 cycles apart, and never closer.
REQ-020 Arbitration (default): when both reqs are high in IDLE, the requester not granted last SHALL win; a single requester SHALL win regardless of history.
REQ-021 last-granted SHALL be set to 1 by reset, so requester 0 wins the first tie.
REQ-022 Requests arriving during GRANT or WAIT SHALL be ignored until IDLE and SHALL not be lost if held.
REQ-023 A req dropped before its gnt SHALL cause no transmission, and no gnt SHALL be issued to it.
REQ-024 write_value SHALL keep the last transmitted byte outside GRANT.

Reset
REQ-025 Reset SHALL force state=IDLE, write=0, gnt0=0, gnt1=0, busy=0, write_value=8'h00, counter=0, last-granted=1, on the next rising edge.
REQ-026 Reset asserted in GRANT or WAIT SHALL abort the wait immediately, so the next transmission may start without the frame delay.
REQ-027 After reset deasserts, a held request SHALL be granted within 2 cycles.

Configuration
REQ-028 Macro UART_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win ties, and the last-granted register SHALL not exist.
REQ-029 When UART_ARB_FIXED_PRIO_EN is undefined, the block SHALL use the round-robin rule of REQ-020.

Verification (CLKS_PER_BIT=4, FRAME_BITS=11, FRAME_CYCLES=44)
REQ-030 Reset, then req0=1 with data0=8'h12 held -> gnt0 and write high for 1 cycle, write_value=8'h12, busy high for 45 cycles, then low.
REQ-031 req0 and req1 both held high, data0=8'h34, data1=8'h56 -> grants alternate 0,1,0,1 with write_value 34,56,34,56, and write edges 46 cycles apart.
REQ-032 Same stimulus with UART_ARB_FIXED_PRIO_EN defined -> only gnt0 is issued, write_value is always 8'h34, and req1 is starved.
REQ-033 req1 raised 10 cycles into WAIT with data1=8'h78 -> no grant until IDLE, gnt1 exactly 46 cycles after the previous write.
REQ-034 Reset pulsed mid-WAIT with req0 held, data0=8'h9A -> busy=0 on the edge after reset, write with 8'h9A within 2 cycles of reset deassertion.
REQ-035 req0 pulsed high for 1 cycle during WAIT, then low -> no write and no gnt0 is ever issued for it.
